keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment driver. It scans a 4x4 matrix hex keypad one column at a time, in the same way the display driver strobes one digit at a time.
- It debounces key presses and releases, then reports each press as a 4-bit hex key code with a one-cycle valid strobe.
- The key codes feed the calculator's operand and operation entry logic.

---
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. It debounces
// presses and releases, then reports each accepted press as a hex key code
// with a one-cycle strobe.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   row[3:0]     keypad rows, active-low, asynchronous to clk
//   col[3:0]     column drive, active-low, one-hot-low
//   key_code     hex code of the last accepted key
//   key_valid    one-cycle pulse when a new key is accepted
//   key_held     high while the accepted key remains pressed
//   o_dbg_state  current FSM state (debug observation only)
//
// Handshake: key_valid is a single-cycle qualifier with no ready. key_code is
// valid in the cycle key_valid is high and holds until the next accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam int             CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB_MAX = 4'(DEBOUNCE_SCANS);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_sync1, r_row_s;
  logic [3:0]    r_col, w_col_nx;
  logic [3:0]    r_deb, w_deb_nx;
  logic [1:0]    r_cand, w_cand_nx;
  logic [3:0]    r_code, w_code_nx;
  logic          r_valid, w_valid_nx;
  logic          r_held, w_held_nx;

  logic          w_tick;
  logic          w_single;
  logic          w_idle;
  logic [1:0]    w_row_idx;
  logic [1:0]    w_col_idx;
  logic [3:0]    w_col_rot;
  logic [3:0]    w_deb_inc;
  logic          w_accept;
  logic [1:0]    w_acc_row;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;  4'b11_01: k = 4'h0;  4'b11_10: k = 4'hF;  default:  k = 4'hD;
    endcase
    return k;
  endfunction

  assign w_tick    = (r_cnt == CNT_MAX);
  assign w_idle    = (r_row_s == 4'b1111);
  assign w_col_rot = {r_col[2:0], r_col[3]};
  assign w_deb_inc = r_deb + 4'd1;

  // Exactly one low row is a usable press; multiple low rows are ghosts.
  always_comb begin
    w_single  = 1'b0;
    w_row_idx = 2'd0;
    case (r_row_s)
      4'b1110: begin w_single = 1'b1; w_row_idx = 2'd0; end
      4'b1101: begin w_single = 1'b1; w_row_idx = 2'd1; end
      4'b1011: begin w_single = 1'b1; w_row_idx = 2'd2; end
      4'b0111: begin w_single = 1'b1; w_row_idx = 2'd3; end
      default: begin w_single = 1'b0; w_row_idx = 2'd0; end
    endcase
  end

  always_comb begin
    case (r_col)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Next-state logic. Everything only advances on a column tick, except
  // key_valid, which defaults low so it can only ever last one cycle.
  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_deb_nx   = r_deb;
    w_cand_nx  = r_cand;
    w_code_nx  = r_code;
    w_valid_nx = 1'b0;
    w_held_nx  = r_held;
    w_accept   = 1'b0;
    w_acc_row  = r_cand;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_single) begin
            w_cand_nx = w_row_idx;
            if (DEBOUNCE_SCANS == 1) begin
              w_accept  = 1'b1;
              w_acc_row = w_row_idx;
            end else begin
              w_deb_nx   = 4'd1;
              w_state_nx = ST_DEBOUNCE;
            end
          end else begin
            w_col_nx = w_col_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (w_single && (w_row_idx == r_cand)) begin
            if (w_deb_inc == DEB_MAX) begin
              w_accept  = 1'b1;
              w_acc_row = r_cand;
            end else begin
              w_deb_nx = w_deb_inc;
            end
          end else begin
            w_state_nx = ST_SCAN;
            w_col_nx   = w_col_rot;
            w_deb_nx   = 4'd0;
          end
        end
        ST_HELD: begin
          // Column stays frozen, so only the held key's column is watched;
          // a release is a run of idle samples on that column.
          if (w_idle) begin
            if (w_deb_inc == DEB_MAX) begin
              w_held_nx  = 1'b0;
              w_deb_nx   = 4'd0;
              w_state_nx = ST_SCAN;
              w_col_nx   = w_col_rot;
            end else begin
              w_deb_nx = w_deb_inc;
            end
          end else begin
            w_deb_nx = 4'd0;
          end
        end
        default: begin
          w_state_nx = ST_SCAN;
          w_deb_nx   = 4'd0;
        end
      endcase
    end
    if (w_accept) begin
      w_code_nx  = key_map(w_acc_row, w_col_idx);
      w_valid_nx = 1'b1;
      w_held_nx  = 1'b1;
      w_deb_nx   = 4'd0;
      w_state_nx = ST_HELD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SCAN;
      r_cnt   <= '0;
      r_sync1 <= 4'b1111;
      r_row_s <= 4'b1111;
      r_col   <= 4'b1110;
      r_deb   <= 4'd0;
      r_cand  <= 2'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
      r_sync1 <= row;
      r_row_s <= r_sync1;
      r_col   <= w_col_nx;
      r_deb   <= w_deb_nx;
      r_cand  <= w_cand_nx;
      r_code  <= w_code_nx;
      r_valid <= w_valid_nx;
      r_held  <= w_held_nx;
    end
  end

  assign col         = r_col;
  assign key_code    = r_code;
  assign key_valid   = r_valid;
  assign key_held    = r_held;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model pulls rows low from the pressed-key matrix and the driven
// columns. Expected key codes go into exp_q when a press is staged; a monitor
// pops them on every key_valid pulse.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;

  logic [3:0] pressed [4];   // pressed[r][c]
  logic [3:0] exp_q [$];

  int n_vec   = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .o_dbg_state(dbg_state)
  );

  // Matrix model: a row reads low if any pressed key in it sits on a driven column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      if ((pressed[r] & ~col) != 4'b0000) row[r] = 1'b0;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [3:0] e;
    if (key_valid === 1'b1) begin
      n_pulse++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_key_valid: got code %0h, expected no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          n_fail++;
          $display("FAIL key_code_on_valid: got %0h expected %0h", key_code, e);
        end
      end
      n_vec++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL key_valid_two_cycles: got 2 consecutive cycles, expected 1");
      end
    end
    prev_valid = (key_valid === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int r, input int c);
    pressed[r][c] = 1'b1;
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  // Wait for a fresh transition of col into target.
  task automatic wait_col(input logic [3:0] t);
    int k;
    k = 0;
    while (col === t && k < 40) begin step(1); k++; end
    while (col !== t && k < 40) begin step(1); k++; end
    check("wait_col_timeout", col, t);
  endtask

  task automatic wait_held(input logic v, input int max, output int n);
    n = 0;
    while (key_held !== v && n < max) begin step(1); n++; end
    check("wait_held_timeout", key_held, v);
  endtask

  initial begin
    int n;
    int p;
    int bad;
    release_all();
    rst_n = 1'b0;

    // 1. Reset values and column rotation.
    step(3);
    check("rst_col", col, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    rst_n = 1'b1;
    step(3);
    check("col_before_first_tick", col, 4'b1110);
    step(1);
    check("col_step1", col, 4'b1101);
    step(4);
    check("col_step2", col, 4'b1011);
    step(4);
    check("col_step3", col, 4'b0111);
    step(4);
    check("col_wrap", col, 4'b1110);

    // 2. Clean press of '5' (r1,c1).
    p = n_pulse;
    exp_q.push_back(4'h5);
    press(1, 1);
    wait_held(1'b1, 60, n);
    step(1);
    check("p5_pulse_count", n_pulse - p, 1);
    check("p5_key_code", key_code, 4'h5);
    check("p5_col", col, 4'b1101);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (col !== 4'b1101 || key_held !== 1'b1) bad++;
    end
    check("p5_frozen_while_held", bad, 0);
    check("p5_no_repeat", n_pulse - p, 1);
    release_all();
    wait_held(1'b0, 30, n);
    check("p5_release_window", (n >= 11 && n <= 16), 1'b1);
    check("p5_scan_resumes", col, 4'b1011);
    step(4);
    check("p5_scan_next", col, 4'b0111);

    // 3. Bounce on 'D' (r3,c3): single, idle, then stable.
    p = n_pulse;
    wait_col(4'b0111);
    press(3, 3);
    step(4);
    release_all();
    step(4);
    press(3, 3);
    step(4);
    check("bounce_no_pulse", n_pulse - p, 0);
    exp_q.push_back(4'hD);
    wait_held(1'b1, 80, n);
    step(1);
    check("d_pulse_count", n_pulse - p, 1);
    check("d_key_code", key_code, 4'hD);
    release_all();
    wait_held(1'b0, 40, n);

    // 4. Short glitch on '0' (r3,c1) lasting two ticks.
    p = n_pulse;
    wait_col(4'b1101);
    press(3, 1);
    step(8);
    release_all();
    step(4);
    check("glitch_back_to_scan", col, 4'b1011);
    step(20);
    check("glitch_no_pulse", n_pulse - p, 0);
    check("glitch_code_kept", key_code, 4'hD);

    // 5. Ghost: '1' and '4' share column 0.
    p = n_pulse;
    press(0, 0);
    press(1, 0);
    wait_col(4'b1110);
    step(4);
    check("ghost_scan_continues", col, 4'b1101);
    step(30);
    check("ghost_no_pulse", n_pulse - p, 0);
    release_all();
    step(8);
    // Second key while first is held.
    exp_q.push_back(4'h7);
    press(2, 0);
    wait_held(1'b1, 60, n);
    step(2);
    check("k7_pulse_count", n_pulse - p, 1);
    p = n_pulse;
    press(2, 2);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (col !== 4'b1110 || key_held !== 1'b1) bad++;
    end
    check("second_key_frozen", bad, 0);
    check("second_key_no_pulse", n_pulse - p, 0);
    release_all();
    wait_held(1'b0, 40, n);
    step(20);
    check("both_released_no_pulse", n_pulse - p, 0);

    // 6. Reset while 'A' (r0,c3) is held.
    p = n_pulse;
    exp_q.push_back(4'hA);
    press(0, 3);
    wait_held(1'b1, 60, n);
    step(2);
    check("a_pulse_count", n_pulse - p, 1);
    rst_n = 1'b0;
    step(1);
    check("rst_held_col", col, 4'b1110);
    check("rst_held_key_code", key_code, 4'h0);
    check("rst_held_key_valid", key_valid, 1'b0);
    check("rst_held_key_held", key_held, 1'b0);
    rst_n = 1'b1;
    exp_q.push_back(4'hA);
    wait_held(1'b1, 60, n);
    step(2);
    check("a_redetect_pulse_count", n_pulse - p, 2);
    check("a_redetect_code", key_code, 4'hA);
    release_all();
    wait_held(1'b0, 40, n);
    step(4);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
